set_multi_counter: RTL

//  Parametrised successor to the single-pass set counter. Scans a GRID_N x GRID_N lattice, one point per cycle, through a 2-stage pipeline.

---
 rtl/set_pkg.sv | 53 +++++
 rtl/set_point_member.sv | 51 +++++
 rtl/set_multi_counter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared definitions for the lattice set counter.
//   - mode codes selecting the set expression over circles A, B, C
//   - FSM state encoding and the drain length
//   - width helpers for the point counter and the squared distance
//   - set_eval: maps the three membership bits and a mode to a hit bit
package set_pkg;

  localparam logic [2:0] MODE_A    = 3'd0;  // A
  localparam logic [2:0] MODE_AND  = 3'd1;  // A & B
  localparam logic [2:0] MODE_XOR  = 3'd2;  // A ^ B
  localparam logic [2:0] MODE_OR   = 3'd3;  // A | B
  localparam logic [2:0] MODE_DIFF = 3'd4;  // A & ~B
  localparam logic [2:0] MODE_TWO3 = 3'd5;  // exactly two of A, B, C

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // After the last point is issued, the issue, distance and compare
  // registers each need one edge to empty before the count is final.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  function automatic int cnt_width(input int grid_n);
    return $clog2(grid_n * grid_n + 1);
  endfunction

  // Squared distance of two COORD_W-bit points never exceeds 2*(2^W-1)^2.
  function automatic int d2_width(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

  function automatic logic set_eval(input logic [2:0] mode,
                                    input logic in_a,
                                    input logic in_b,
                                    input logic in_c);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_A:    hit = in_a;
      MODE_AND:  hit = in_a & in_b;
      MODE_XOR:  hit = in_a ^ in_b;
      MODE_OR:   hit = in_a | in_b;
      MODE_DIFF: hit = in_a & ~in_b;
      MODE_TWO3: hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) |
                       (~in_a & in_b & in_c);
      default:   hit = 1'b0;  // reserved modes count nothing
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/set_point_member.sv
// Two-stage membership test of one lattice point against one circle.
//   Stage 1 registers d2 = (x-cx)^2 + (y-cy)^2 using signed differences.
//   Stage 2 registers in_k = (d2 <= r^2), boundary inclusive.
// Ports:
//   clk        rising-edge clock
//   x, y       lattice point being tested
//   cx, cy, r  circle centre and radius (unsigned)
//   in_k       registered membership bit, two edges after x/y
module set_point_member
  import set_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  output logic               in_k
);

  localparam int D2_W = d2_width(COORD_W);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic signed [D2_W-1:0]  dx_ext;
  logic signed [D2_W-1:0]  dy_ext;
  logic        [D2_W-1:0]  r_ext;
  logic        [D2_W-1:0]  r_sq;
  logic        [D2_W-1:0]  d2_next;
  logic        [D2_W-1:0]  d2_reg;

  always_comb begin
    // Zero-extend before subtracting so off-lattice centres (0 or > GRID_N)
    // produce correct negative differences.
    dx      = $signed({1'b0, x}) - $signed({1'b0, cx});
    dy      = $signed({1'b0, y}) - $signed({1'b0, cy});
    dx_ext  = {{(D2_W-COORD_W-1){dx[COORD_W]}}, dx};
    dy_ext  = {{(D2_W-COORD_W-1){dy[COORD_W]}}, dy};
    d2_next = $unsigned(dx_ext * dx_ext) + $unsigned(dy_ext * dy_ext);
    r_ext   = {{(D2_W-COORD_W){1'b0}}, r};
    r_sq    = r_ext * r_ext;
  end

  always_ff @(posedge clk) begin
    d2_reg <= d2_next;
    in_k   <= (d2_reg <= r_sq);
  end

endmodule

// File: rtl/set_multi_counter.sv
// Lattice set counter: scans a GRID_N x GRID_N lattice one point per cycle
// and counts the points satisfying the selected set expression over up to
// three circles.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts a scan in progress
//   en         start request, accepted only while busy = 0
//   central    {Ax,Ay,Bx,By,Cx,Cy}, MSB first, latched on accept
//   radius     {rA,rB,rC}, MSB first, latched on accept
//   mode       set expression code (see set_pkg), latched on accept
//   busy       scan in progress
//   valid      one-cycle strobe when candidate holds the final count
//   candidate  point count, held until the next accepted en
module set_multi_counter
  import set_pkg::*;
#(
  parameter  int COORD_W = 4,
  parameter  int GRID_N  = 8,
  parameter  int NCIRC   = 3,
  localparam int CNT_W   = cnt_width(GRID_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2*COORD_W*NCIRC-1:0] central,
  input  logic [COORD_W*NCIRC-1:0]   radius,
  input  logic [2:0]                 mode,
  output logic                       busy,
  output logic                       valid,
  output logic [CNT_W-1:0]           candidate
);

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] GRID_MAX  = COORD_W'(GRID_N);

  state_t                     state_reg;
  logic [COORD_W-1:0]         x_reg;
  logic [COORD_W-1:0]         y_reg;
  logic [COORD_W-1:0]         pt_x_reg;
  logic [COORD_W-1:0]         pt_y_reg;
  logic                       pt_vld_reg;
  logic                       s1_vld_reg;
  logic                       s2_vld_reg;
  logic [1:0]                 drain_cnt_reg;
  logic [2*COORD_W*NCIRC-1:0] central_reg;
  logic [COORD_W*NCIRC-1:0]   radius_reg;
  logic [2:0]                 mode_reg;
  logic [2:0]                 in_vec;   // [0]=A, [1]=B, [2]=C
  logic                       hit;

  // One membership pipeline per circle; a missing circle C reads as empty.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_circ
      if (gi < NCIRC) begin : g_live
        set_point_member #(
          .COORD_W(COORD_W)
        ) u_member (
          .clk (clk),
          .x   (pt_x_reg),
          .y   (pt_y_reg),
          .cx  (central_reg[(2*NCIRC-1-2*gi)*COORD_W +: COORD_W]),
          .cy  (central_reg[(2*NCIRC-2-2*gi)*COORD_W +: COORD_W]),
          .r   (radius_reg[(NCIRC-1-gi)*COORD_W +: COORD_W]),
          .in_k(in_vec[gi])
        );
      end else begin : g_empty
        assign in_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign hit = set_eval(mode_reg, in_vec[0], in_vec[1], in_vec[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= COORD_ONE;
      y_reg         <= COORD_ONE;
      pt_x_reg      <= COORD_ONE;
      pt_y_reg      <= COORD_ONE;
      pt_vld_reg    <= 1'b0;
      s1_vld_reg    <= 1'b0;
      s2_vld_reg    <= 1'b0;
      drain_cnt_reg <= 2'd0;
      central_reg   <= '0;
      radius_reg    <= '0;
      mode_reg      <= MODE_A;
      busy          <= 1'b0;
      valid         <= 1'b0;
      candidate     <= '0;
    end else begin
      valid      <= 1'b0;
      pt_vld_reg <= 1'b0;
      // Valid bits travel alongside the per-circle distance/compare stages.
      s1_vld_reg <= pt_vld_reg;
      s2_vld_reg <= s1_vld_reg;

      if (s2_vld_reg && hit) begin
        candidate <= candidate + CNT_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (en) begin
            central_reg <= central;
            radius_reg  <= radius;
            mode_reg    <= mode;
            candidate   <= '0;
            busy        <= 1'b1;
            x_reg       <= COORD_ONE;
            y_reg       <= COORD_ONE;
            state_reg   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          pt_x_reg   <= x_reg;
          pt_y_reg   <= y_reg;
          pt_vld_reg <= 1'b1;
          if (y_reg == GRID_MAX) begin
            y_reg <= COORD_ONE;
            if (x_reg == GRID_MAX) begin
              x_reg         <= COORD_ONE;
              drain_cnt_reg <= 2'd0;
              state_reg     <= ST_DRAIN;
            end else begin
              x_reg <= x_reg + COORD_ONE;
            end
          end else begin
            y_reg <= y_reg + COORD_ONE;
          end
        end

        ST_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + 2'd1;
          // The last point's increment lands on this same edge, so the
          // count is complete when valid becomes visible.
          if (drain_cnt_reg == DRAIN_LAST) begin
            busy      <= 1'b0;
            valid     <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
